branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic conditional-branch predictor for the five-stage RISC-V core.
- Fetch/decode side: supplies the `br_taken` guess that travels with each branch down the pipe.
- Execute side: consumes the execute-stage resolution (`br_suc` / `br_mispred`) to train a table of 2-bit saturating counters.
- Optionally hashes a global history register into the index (gshare).
- Keeps two 32-bit performance counters for CSR readout.

## Interface
- `ENTRIES`, 32: counter-table depth; power of two, ≥4; `IDXW = log2(ENTRIES)`.
- `HIST_BITS`, 5: global history length, 1..IDXW; ignored without gshare.

Clock and reset are fixed: one clock; reset is synchronous and active-high.
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `pc_guess`  in  32  PC of instruction being predicted (decode).
- `is_br_guess`  in  1  that instruction is a conditional branch.
- `stall`  in  1  decode stalled; prediction not consumed this cycle.
- `br_taken`  out  1  predicted direction for `pc_guess`.
- `pc_check`  in  32  PC of branch in execute.
- `is_br_check`  in  1  execute instruction is a conditional branch.
- `br_taken_check`  in  1  prediction carried with that branch.
- `br_suc`  in  1  execute reports correct prediction.
- `br_mispred`  in  1  execute reports misprediction.
- `flush`  in  1  execute-stage redirect; younger instructions squashed.
- `pred_count`  out  32  resolved branches.
- `mispred_count`  out  32  mispredicted branches.

## Operation
- Table: `ENTRIES` × 2-bit counters, reset value 2'b01 (weakly not-taken).
- Predict: `br_taken = table[idx_g][1]`.
  - `br_taken` is 0 whenever `is_br_guess` = 0.
- Index:
  - `idx_g = pc_guess[IDXW+1:2] ^ ghr_spec`
  - `idx_c = pc_check[IDXW+1:2] ^ ghr_commit`
  - History is zero-extended to IDXW.
- Resolve: occurs when `is_br_check && (br_suc || br_mispred)`.
  - Both flags high: treated as a mispredict.
  - `actual = br_taken_check ^ mispred`.
  - Counter at `idx_c` moves +1 if `actual`, −1 otherwise, saturating at 3 and 0.
  - `pred_count` += 1; `mispred_count` += 1 on a mispredict.
- `br_suc` / `br_mispred` with `is_br_check` = 0: ignored.
- History registers (HIST_BITS wide, reset 0), updated in priority order:
  - `rst`: all state cleared.
  - Resolve: `ghr_commit <= {ghr_commit[H-2:0], actual}`.
  - `ghr_spec`:
    - Mispredict: `{ghr_commit[H-2:0], actual}`.
    - Else `flush`: the post-update `ghr_commit`.
    - Else `is_br_guess && !stall`: `{ghr_spec[H-2:0], br_taken}`.
    - Else: hold.
- Wrong-path guesses in the same cycle as a mispredict or flush are discarded from history.
- Perf counters wrap 0xFFFF_FFFF → 0, no saturation.

## Timing
- `br_taken`: combinational from `pc_guess`, table and `ghr_spec`; zero-cycle latency.
- Table, GHR and perf-counter updates are visible the cycle after resolve.
- Same-entry read and write in one cycle: the prediction uses the pre-update counter (read-before-write).
- `rst` mid-operation clears table, both GHRs and perf counters on that edge. Outputs after reset:
  - `br_taken` = 0.
  - `pred_count` = 0.
  - `mispred_count` = 0.
- `stall` blocks only the speculative history shift; it does not block resolve or flush.

## Configuration
- `BRANCH_PRED_GSHARE_EN` defined:
  - GHRs built.
  - Index hashed with history as above.
- `BRANCH_PRED_GSHARE_EN` undefined:
  - GHRs removed.
  - `idx_g = pc_guess[IDXW+1:2]`, `idx_c = pc_check[IDXW+1:2]`.
  - `flush` has no effect.
  - `HIST_BITS` unused.

## Test plan
- Reset: `rst` 1 cycle, then `pc_guess` = 0x100, `is_br_guess` = 1 → `br_taken` = 0; both perf counters = 0.
- Training (no gshare):
  - Resolve pc 0x100 taken twice (`br_taken_check` = 0 + mispred, then `br_taken_check` = 1 + suc) → `br_taken` = 1 for 0x100.
  - Three not-taken mispredicts → `br_taken` = 0.
  - `pred_count` = 5, `mispred_count` = 4.
- Saturation: 6 taken resolves at 0x200, then one not-taken → prediction stays 1; a second not-taken → prediction 0.
- Gshare history:
  - Three guesses with `br_taken` = 1 and no stall → `ghr_spec` = 0b00111.
  - Then mispredict with `ghr_commit` = 0, actual = 0 → `ghr_spec` = 0 next cycle.
  - `flush` alone restores `ghr_spec` to `ghr_commit`.
- Stall: `is_br_guess` = 1, `stall` = 1 for 3 cycles → `ghr_spec` unchanged.
- Collision and wrap:
  - Guess and resolve on the same index in one cycle → old prediction output; new value the next cycle.
  - `pred_count` forced near 0xFFFF_FFFF → next resolve gives 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Two-bit saturating-counter branch predictor with CSR-visible perf counters.
// Define BRANCH_PRED_GSHARE_EN to hash global history into the table index.
module branch_predictor #(
    parameter int ENTRIES   = 32,
    parameter int HIST_BITS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_guess_i,
    input  logic        is_br_guess_i,
    input  logic        stall_i,
    output logic        br_taken_o,
    input  logic [31:0] pc_check_i,
    input  logic        is_br_check_i,
    input  logic        br_taken_check_i,
    input  logic        br_suc_i,
    input  logic        br_mispred_i,
    input  logic        flush_i,
    output logic [31:0] pred_count_o,
    output logic [31:0] mispred_count_o
);

    localparam int IDXW = $clog2(ENTRIES);

    logic [1:0]      table_q [ENTRIES];
    logic [1:0]      ctr_d;
    logic [IDXW-1:0] idx_g;
    logic [IDXW-1:0] idx_c;
    logic            resolve;
    logic            mispred;
    logic            actual;
    logic [31:0]     pred_count_q;
    logic [31:0]     pred_count_d;
    logic [31:0]     mispred_count_q;
    logic [31:0]     mispred_count_d;
    logic            unused_pc;

    // Both flags high counts as a mispredict.
    assign resolve = is_br_check_i & (br_suc_i | br_mispred_i);
    assign mispred = resolve & br_mispred_i;
    assign actual  = br_taken_check_i ^ mispred;

`ifdef BRANCH_PRED_GSHARE_EN
    logic [HIST_BITS-1:0] ghr_spec_q;
    logic [HIST_BITS-1:0] ghr_spec_d;
    logic [HIST_BITS-1:0] ghr_commit_q;
    logic [HIST_BITS-1:0] ghr_commit_d;

    always_comb begin
        ghr_commit_d = ghr_commit_q;
        if (resolve) begin
            ghr_commit_d = HIST_BITS'({ghr_commit_q, actual});
        end
        ghr_spec_d = ghr_spec_q;
        // Redirect wins over any wrong-path guess in the same cycle.
        if (mispred || flush_i) begin
            ghr_spec_d = ghr_commit_d;
        end else if (is_br_guess_i && !stall_i) begin
            ghr_spec_d = HIST_BITS'({ghr_spec_q, br_taken_o});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_spec_q   <= '0;
            ghr_commit_q <= '0;
        end else begin
            ghr_spec_q   <= ghr_spec_d;
            ghr_commit_q <= ghr_commit_d;
        end
    end

    assign idx_g = pc_guess_i[IDXW+1:2] ^ IDXW'(ghr_spec_q);
    assign idx_c = pc_check_i[IDXW+1:2] ^ IDXW'(ghr_commit_q);
`else
    logic unused_cfg;

    assign idx_g      = pc_guess_i[IDXW+1:2];
    assign idx_c      = pc_check_i[IDXW+1:2];
    assign unused_cfg = flush_i ^ (HIST_BITS > 0);
`endif

    assign unused_pc = ^{pc_guess_i[31:IDXW+2], pc_guess_i[1:0],
                         pc_check_i[31:IDXW+2], pc_check_i[1:0]};

    // Read uses the registered table, so a same-cycle write is seen next cycle.
    assign br_taken_o = is_br_guess_i & table_q[idx_g][1];

    always_comb begin
        ctr_d = table_q[idx_c];
        if (actual && (ctr_d != 2'd3)) begin
            ctr_d = ctr_d + 2'd1;
        end else if (!actual && (ctr_d != 2'd0)) begin
            ctr_d = ctr_d - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= 2'b01;
            end
        end else if (resolve) begin
            table_q[idx_c] <= ctr_d;
        end
    end

    assign pred_count_d    = pred_count_q + {31'd0, resolve};
    assign mispred_count_d = mispred_count_q + {31'd0, mispred};

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_count_q    <= '0;
            mispred_count_q <= '0;
        end else begin
            pred_count_q    <= pred_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign pred_count_o    = pred_count_q;
    assign mispred_count_o = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus random traffic against a table model.
// Compile with BRANCH_PRED_GSHARE_EN to also exercise the history registers.
module tb_branch_predictor;

    localparam int ENTRIES = 32;
    localparam int HB      = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_guess;
    logic        is_br_guess;
    logic        stall;
    logic        br_taken;
    logic [31:0] pc_check;
    logic        is_br_check;
    logic        br_taken_check;
    logic        br_suc;
    logic        br_mispred;
    logic        flush;
    logic [31:0] pred_count;
    logic [31:0] mispred_count;

    int checks = 0;
    int errors = 0;

    // Reference state: plain integers for the counters and histories.
    int       m_tbl [ENTRIES];
    int       m_gs;
    int       m_gc;
    bit [31:0] m_pc;
    bit [31:0] m_mp;
    logic     obs_pred;
    bit       exp_pred;

    branch_predictor #(.ENTRIES(ENTRIES), .HIST_BITS(HB)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_guess_i       (pc_guess),
        .is_br_guess_i    (is_br_guess),
        .stall_i          (stall),
        .br_taken_o       (br_taken),
        .pc_check_i       (pc_check),
        .is_br_check_i    (is_br_check),
        .br_taken_check_i (br_taken_check),
        .br_suc_i         (br_suc),
        .br_mispred_i     (br_mispred),
        .flush_i          (flush),
        .pred_count_o     (pred_count),
        .mispred_count_o  (mispred_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int tbl_index(bit [31:0] pc, int hist);
        int idx;
        idx = int'((pc >> 2) % ENTRIES);
`ifdef BRANCH_PRED_GSHARE_EN
        idx = idx ^ hist;
`else
        idx = idx + 0 * hist;
`endif
        return idx;
    endfunction

    function automatic bit model_pred(bit [31:0] pc, bit isbr);
        return isbr && (m_tbl[tbl_index(pc, m_gs)] >= 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_tbl[i] = 1;
        m_gs = 0;
        m_gc = 0;
        m_pc = 0;
        m_mp = 0;
    endtask

    task automatic model_update(bit pred);
        bit res;
        bit mis;
        bit act;
        int idx;
        int new_gc;
        res = is_br_check && (br_suc || br_mispred);
        mis = res && br_mispred;
        act = br_taken_check ^ mis;
        new_gc = m_gc;
        if (res) begin
            idx = tbl_index(pc_check, m_gc);
            if (act) m_tbl[idx] = (m_tbl[idx] == 3) ? 3 : m_tbl[idx] + 1;
            else     m_tbl[idx] = (m_tbl[idx] == 0) ? 0 : m_tbl[idx] - 1;
            m_pc = m_pc + 1;
            if (mis) m_mp = m_mp + 1;
            new_gc = ((m_gc * 2) + int'(act)) % (1 << HB);
        end
`ifdef BRANCH_PRED_GSHARE_EN
        if (mis || flush) m_gs = new_gc;
        else if (is_br_guess && !stall) m_gs = ((m_gs * 2) + int'(pred)) % (1 << HB);
        m_gc = new_gc;
`endif
    endtask

    task automatic clr();
        pc_guess       = 32'h0;
        is_br_guess    = 1'b0;
        stall          = 1'b0;
        pc_check       = 32'h0;
        is_br_check    = 1'b0;
        br_taken_check = 1'b0;
        br_suc         = 1'b0;
        br_mispred     = 1'b0;
        flush          = 1'b0;
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic step();
        #1;
        obs_pred = br_taken;
        exp_pred = model_pred(pc_guess, is_br_guess);
        model_update(exp_pred);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic resolve_at(bit [31:0] pc, bit btc, bit suc, bit mis);
        clr();
        pc_check       = pc;
        is_br_check    = 1'b1;
        br_taken_check = btc;
        br_suc         = suc;
        br_mispred     = mis;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        pc_guess    = 32'h100;
        is_br_guess = 1'b1;
        #1;
        checks++;
        if (br_taken !== 1'b0) begin errors++; $display("FAIL reset_br_taken: got %0b expected 0", br_taken); end
        checks++;
        if (pred_count !== 32'd0) begin errors++; $display("FAIL reset_pred_count: got %0h expected 0", pred_count); end
        checks++;
        if (mispred_count !== 32'd0) begin errors++; $display("FAIL reset_mispred_count: got %0h expected 0", mispred_count); end
        @(negedge clk);
    endtask

    task automatic test_training();
        do_reset();
        resolve_at(32'h100, 1'b0, 1'b0, 1'b1);
        resolve_at(32'h100, 1'b1, 1'b1, 1'b0);
        clr(); pc_guess = 32'h100; is_br_guess = 1'b1; step();
        checks++;
        if (obs_pred !== exp_pred) begin errors++; $display("FAIL train_taken_model: got %0b expected %0b", obs_pred, exp_pred); end
`ifndef BRANCH_PRED_GSHARE_EN
        checks++;
        if (obs_pred !== 1'b1) begin errors++; $display("FAIL train_taken: got %0b expected 1", obs_pred); end
`endif
        for (int i = 0; i < 3; i++) resolve_at(32'h100, 1'b1, 1'b0, 1'b1);
        clr(); pc_guess = 32'h100; is_br_guess = 1'b1; step();
        checks++;
        if (obs_pred !== exp_pred) begin errors++; $display("FAIL train_nt_model: got %0b expected %0b", obs_pred, exp_pred); end
`ifndef BRANCH_PRED_GSHARE_EN
        checks++;
        if (obs_pred !== 1'b0) begin errors++; $display("FAIL train_nt: got %0b expected 0", obs_pred); end
`endif
        checks++;
        if (pred_count !== 32'd5) begin errors++; $display("FAIL train_pred_count: got %0d expected 5", pred_count); end
        checks++;
        if (mispred_count !== 32'd4) begin errors++; $display("FAIL train_mispred_count: got %0d expected 4", mispred_count); end
    endtask

    task automatic test_saturation();
        bit [1:0] seen;
        do_reset();
        for (int i = 0; i < 6; i++) resolve_at(32'h200, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            resolve_at(32'h200, 1'b1, 1'b0, 1'b1);
            clr(); pc_guess = 32'h200; is_br_guess = 1'b1; step();
            seen[k] = obs_pred;
            checks++;
            if (obs_pred !== exp_pred) begin errors++; $display("FAIL sat_model_%0d: got %0b expected %0b", k, obs_pred, exp_pred); end
        end
`ifndef BRANCH_PRED_GSHARE_EN
        checks++;
        if (seen !== 2'b01) begin errors++; $display("FAIL sat_sequence: got %b expected 01 (second,first)", seen); end
`endif
        checks++;
        if (pred_count !== 32'd8) begin errors++; $display("FAIL sat_pred_count: got %0d expected 8", pred_count); end
    endtask

`ifdef BRANCH_PRED_GSHARE_EN
    task automatic test_gshare();
        do_reset();
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < ENTRIES; i++) resolve_at(32'(i * 4), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < HB; i++) resolve_at(32'h40, 1'b0, 1'b1, 1'b0);
        checks++;
        if (dut.ghr_spec_q !== 5'd0) begin errors++; $display("FAIL gs_start: got %0h expected 0", dut.ghr_spec_q); end
        for (int i = 0; i < 3; i++) begin
            clr(); pc_guess = 32'(i * 12); is_br_guess = 1'b1; step();
            checks++;
            if (obs_pred !== 1'b1) begin errors++; $display("FAIL gs_guess_%0d: got %0b expected 1", i, obs_pred); end
        end
        checks++;
        if (dut.ghr_spec_q !== 5'b00111) begin errors++; $display("FAIL gs_spec_shift: got %b expected 00111", dut.ghr_spec_q); end
        clr();
        pc_check = 32'h80; is_br_check = 1'b1; br_taken_check = 1'b1; br_mispred = 1'b1;
        pc_guess = 32'h44; is_br_guess = 1'b1;
        step();
        checks++;
        if (dut.ghr_spec_q !== 5'd0) begin errors++; $display("FAIL gs_mispred_restore: got %b expected 00000", dut.ghr_spec_q); end
        for (int i = 0; i < 3; i++) begin clr(); pc_guess = 32'h10; is_br_guess = 1'b1; step(); end
        clr(); flush = 1'b1; step();
        checks++;
        if (dut.ghr_spec_q !== 5'd0) begin errors++; $display("FAIL gs_flush_restore: got %b expected 00000", dut.ghr_spec_q); end
        checks++;
        if (dut.ghr_spec_q !== 5'(m_gs)) begin errors++; $display("FAIL gs_model: got %b expected %0d", dut.ghr_spec_q, m_gs); end
    endtask
`endif

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            clr(); pc_guess = 32'(i * 4); is_br_guess = 1'b1; stall = 1'b1; step();
            checks++;
            if (obs_pred !== exp_pred) begin errors++; $display("FAIL stall_pred_%0d: got %0b expected %0b", i, obs_pred, exp_pred); end
        end
`ifdef BRANCH_PRED_GSHARE_EN
        checks++;
        if (dut.ghr_spec_q !== 5'd0) begin errors++; $display("FAIL stall_hist: got %b expected 00000", dut.ghr_spec_q); end
`endif
    endtask

    task automatic test_collision();
        do_reset();
        clr();
        pc_guess = 32'h300; is_br_guess = 1'b1;
        pc_check = 32'h300; is_br_check = 1'b1; br_taken_check = 1'b1; br_suc = 1'b1;
        step();
        checks++;
        if (obs_pred !== 1'b0) begin errors++; $display("FAIL coll_old: got %0b expected 0", obs_pred); end
        clr(); pc_guess = 32'h300; is_br_guess = 1'b1; step();
        checks++;
        if (obs_pred !== exp_pred) begin errors++; $display("FAIL coll_next_model: got %0b expected %0b", obs_pred, exp_pred); end
`ifndef BRANCH_PRED_GSHARE_EN
        checks++;
        if (obs_pred !== 1'b1) begin errors++; $display("FAIL coll_next: got %0b expected 1", obs_pred); end
`endif
    endtask

    task automatic test_wrap();
        force dut.pred_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.pred_count_q;
        m_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        resolve_at(32'h20, 1'b1, 1'b0, 1'b1);
        checks++;
        if (pred_count !== 32'd0) begin errors++; $display("FAIL wrap_zero: got %0h expected 0", pred_count); end
        resolve_at(32'h20, 1'b1, 1'b1, 1'b0);
        checks++;
        if (pred_count !== m_pc) begin errors++; $display("FAIL wrap_next: got %0h expected %0h", pred_count, m_pc); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 500; n++) begin
            clr();
            pc_guess       = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15) * 4);
            is_br_guess    = ($urandom_range(0, 3) != 0);
            stall          = ($urandom_range(0, 4) == 0);
            pc_check       = ($urandom_range(0, 3) == 0) ? pc_guess
                           : (($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15) * 4));
            is_br_check    = ($urandom_range(0, 2) != 0);
            br_taken_check = 1'($urandom);
            br_suc         = 1'($urandom);
            br_mispred     = ($urandom_range(0, 2) == 0);
            flush          = ($urandom_range(0, 7) == 0);
            step();
            checks++;
            if (obs_pred !== exp_pred) begin errors++; $display("FAIL rnd_pred[%0d]: got %0b expected %0b", n, obs_pred, exp_pred); end
            checks++;
            if (pred_count !== m_pc) begin errors++; $display("FAIL rnd_pred_count[%0d]: got %0d expected %0d", n, pred_count, m_pc); end
            checks++;
            if (mispred_count !== m_mp) begin errors++; $display("FAIL rnd_mispred_count[%0d]: got %0d expected %0d", n, mispred_count, m_mp); end
`ifdef BRANCH_PRED_GSHARE_EN
            checks++;
            if (dut.ghr_spec_q !== 5'(m_gs)) begin errors++; $display("FAIL rnd_ghr_spec[%0d]: got %0d expected %0d", n, dut.ghr_spec_q, m_gs); end
`endif
        end
    endtask

    initial begin
        clr();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_training();
        test_saturation();
`ifdef BRANCH_PRED_GSHARE_EN
        test_gshare();
`else
        do_reset();
`endif
        test_stall();
        test_collision();
        test_wrap();
        test_random();
        test_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
